// File: rtl/mips_ctrl_pkg.sv
// Shared types for the multicycle MIPS controller: state encoding, opcodes,
// datapath select encodings and the bundled control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WRITE,
        S_MEM_WB,
        S_EXECUTE,
        S_ALU_WB,
        S_BRANCH,
        S_JUMP,
        S_IMM_EXEC,
        S_IMM_WB,
        S_ERR,
        S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_IMM   = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_t;

    typedef enum logic [1:0] {
        SRCB_B      = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } alu_src_b_t;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_MEM,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_IMM,
        CLS_ILLEGAL
    } op_class_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        pc_src_t    pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
        logic       ext_op;
        logic       bus_err;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode classifier; gives the instruction class and the state
// DECODE should move to. Undecoded opcodes report CLS_ILLEGAL.
module opcode_class_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  op_class,
    output state_t     next_hint
);

    always_comb begin
        op_class  = CLS_ILLEGAL;
        next_hint = S_FETCH;
        case (opcode)
            OP_RTYPE: begin
                op_class  = CLS_RTYPE;
                next_hint = S_EXECUTE;
            end
            OP_LW, OP_SW: begin
                op_class  = CLS_MEM;
                next_hint = S_MEM_ADDR;
            end
            OP_BEQ, OP_BNE: begin
                op_class  = CLS_BRANCH;
                next_hint = S_BRANCH;
            end
            OP_J: begin
                op_class  = CLS_JUMP;
                next_hint = S_JUMP;
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
                op_class  = CLS_IMM;
                next_hint = S_IMM_EXEC;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS datapath with memory wait timeout.
// Define ILLEGAL_TRAP_EN to trap undecoded opcodes instead of treating them as NOPs.
//
// state      | meaning
// FETCH      | read instruction at PC, PC+4 on mem_ready
// DECODE     | latch opcode, precompute branch target
// MEM_ADDR   | compute lw/sw effective address
// MEM_READ   | data read, waits on mem_ready
// MEM_WRITE  | data write, waits on mem_ready
// MEM_WB     | load data to rt
// EXECUTE    | R-type ALU operation
// ALU_WB     | ALU result to rd
// BRANCH     | compare, conditional PC update
// JUMP       | PC <- jump target
// IMM_EXEC   | immediate ALU operation
// IMM_WB     | ALU result to rt
// ERR        | memory timeout, held until rst
// TRAP       | illegal opcode, held until rst
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       ext_op,
    output logic       bus_err,
    output logic       illegal
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    state_t          state, state_next;
    logic [5:0]      op_q;
    logic [CW-1:0]   wait_cnt;
    op_class_t       op_class;
    state_t          decode_hint;
    logic            waiting, timeout;
    ctrl_t           ctrl;
    logic            unused_zero;

    // zero is consumed by the PC-write logic outside this block
    assign unused_zero = zero;

    opcode_class_decode u_decode (
        .opcode    (opcode),
        .op_class  (op_class),
        .next_hint (decode_hint)
    );

    assign waiting = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
    // the counter would reach MEM_TIMEOUT on this cycle; mem_ready still wins
    assign timeout = waiting && !mem_ready && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            op_q     <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == S_DECODE)
                op_q <= opcode;
            if (state_next != state)
                wait_cnt <= '0;
            else if (waiting && !mem_ready)
                wait_cnt <= wait_cnt + CW'(1);
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_FETCH:
                if (mem_ready)    state_next = S_DECODE;
                else if (timeout) state_next = S_ERR;
            S_DECODE:
`ifdef ILLEGAL_TRAP_EN
                state_next = (op_class == CLS_ILLEGAL) ? S_TRAP : decode_hint;
`else
                state_next = (op_class == CLS_ILLEGAL) ? S_FETCH : decode_hint;
`endif
            S_MEM_ADDR:  state_next = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:
                if (mem_ready)    state_next = S_MEM_WB;
                else if (timeout) state_next = S_ERR;
            S_MEM_WRITE:
                if (mem_ready)    state_next = S_FETCH;
                else if (timeout) state_next = S_ERR;
            S_EXECUTE:   state_next = S_ALU_WB;
            S_IMM_EXEC:  state_next = S_IMM_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_IMM_WB:
                         state_next = S_FETCH;
            S_ERR, S_TRAP: state_next = state;
            default:     state_next = S_FETCH;
        endcase
    end

    // reset forces every output low, even mid-instruction
    always_comb begin
        ctrl = '0;
        if (!rst) begin
            unique case (state)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALU_ADD;
                    if (mem_ready) begin
                        ctrl.ir_write = 1'b1;
                        ctrl.pc_write = 1'b1;
                        ctrl.pc_src   = PC_ALU;
                    end
                end
                S_DECODE: begin
                    ctrl.alu_src_b = SRCB_IMM_SH;
                    ctrl.ext_op    = 1'b1;
                end
                S_MEM_ADDR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.ext_op    = 1'b1;
                end
                S_MEM_READ: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.i_or_d   = 1'b1;
                end
                S_MEM_WRITE: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.i_or_d    = 1'b1;
                end
                S_MEM_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                S_EXECUTE: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_B;
                    ctrl.alu_op    = ALU_FUNCT;
                end
                S_ALU_WB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_op        = ALU_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_src        = PC_ALUOUT;
                    ctrl.branch_ne     = (op_q == OP_BNE);
                end
                S_JUMP: begin
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PC_JUMP;
                end
                S_IMM_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALU_IMM;
                    ctrl.ext_op    = (op_q == OP_ADDI) || (op_q == OP_SLTI);
                end
                S_IMM_WB:    ctrl.reg_write = 1'b1;
                S_ERR:       ctrl.bus_err = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                S_TRAP:      ctrl.illegal = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign i_or_d        = ctrl.i_or_d;
    assign ir_write      = ctrl.ir_write;
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign branch_ne     = ctrl.branch_ne;
    assign pc_src        = ctrl.pc_src;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign ext_op        = ctrl.ext_op;
    assign bus_err       = ctrl.bus_err;
    assign illegal       = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each driven cycle queues the
// expected control word, a negedge monitor pops and compares.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a, ext_op, bus_err, illegal;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .branch_ne(branch_ne), .pc_src(pc_src), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_op(ext_op),
        .bus_err(bus_err), .illegal(illegal)
    );

    typedef struct packed {
        logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne;
        logic [1:0] pc_src;
        logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b, alu_op;
        logic       ext_op, bus_err, illegal;
    } ov_t;

    typedef struct {
        ov_t   v;
        string name;
    } exp_t;

    localparam ov_t E_ZERO  = '0;
    localparam ov_t E_FWAIT = '{mem_read:1'b1, alu_src_b:2'b01, default:'0};
    localparam ov_t E_FRDY  = '{mem_read:1'b1, ir_write:1'b1, pc_write:1'b1, alu_src_b:2'b01, default:'0};
    localparam ov_t E_DEC   = '{alu_src_b:2'b11, ext_op:1'b1, default:'0};
    localparam ov_t E_MADDR = '{alu_src_a:1'b1, alu_src_b:2'b10, ext_op:1'b1, default:'0};
    localparam ov_t E_MRD   = '{mem_read:1'b1, i_or_d:1'b1, default:'0};
    localparam ov_t E_MWR   = '{mem_write:1'b1, i_or_d:1'b1, default:'0};
    localparam ov_t E_MWB   = '{reg_write:1'b1, mem_to_reg:1'b1, default:'0};
    localparam ov_t E_EXE   = '{alu_src_a:1'b1, alu_op:2'b10, default:'0};
    localparam ov_t E_AWB   = '{reg_write:1'b1, reg_dst:1'b1, default:'0};
    localparam ov_t E_BEQ   = '{alu_src_a:1'b1, alu_op:2'b01, pc_write_cond:1'b1, pc_src:2'b01, default:'0};
    localparam ov_t E_BNE   = '{alu_src_a:1'b1, alu_op:2'b01, pc_write_cond:1'b1, pc_src:2'b01, branch_ne:1'b1, default:'0};
    localparam ov_t E_JMP   = '{pc_write:1'b1, pc_src:2'b10, default:'0};
    localparam ov_t E_IEX0  = '{alu_src_a:1'b1, alu_src_b:2'b10, alu_op:2'b11, default:'0};
    localparam ov_t E_IEX1  = '{alu_src_a:1'b1, alu_src_b:2'b10, alu_op:2'b11, ext_op:1'b1, default:'0};
    localparam ov_t E_IWB   = '{reg_write:1'b1, default:'0};
    localparam ov_t E_ERR   = '{bus_err:1'b1, default:'0};
    localparam ov_t E_TRAP  = '{illegal:1'b1, default:'0};

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, J = 6'b000010, ORI = 6'b001101, ADDI = 6'b001000;
    localparam logic [5:0] BAD = 6'b111111;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic step(input logic r, input logic [5:0] op, input logic rdy,
                        input ov_t e, input string nm);
        @(posedge clk);
        #1;
        rst       = r;
        opcode    = op;
        mem_ready = rdy;
        zero      = ~zero;
        sbq.push_back('{v: e, name: nm});
    endtask

    always @(negedge clk) begin
        exp_t x;
        ov_t  got;
        if (sbq.size() > 0) begin
            x   = sbq.pop_front();
            got = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne,
                   pc_src, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                   ext_op, bus_err, illegal};
            checks++;
            if (got !== x.v) begin
                errors++;
                $display("FAIL %s: got %06h expected %06h", x.name, got, x.v);
            end
        end
    end

    initial begin
        step(1, R, 0, E_ZERO, "reset0");
        step(1, R, 1, E_ZERO, "reset1");
        // add: 4 cycles
        step(0, R, 1, E_FRDY, "add_fetch");
        step(0, R, 1, E_DEC,  "add_decode");
        step(0, R, 1, E_EXE,  "add_exec");
        step(0, R, 1, E_AWB,  "add_wb");
        // lw with 3 wait states, ready arriving just as the counter would time out
        step(0, LW, 1, E_FRDY,  "lw_fetch");
        step(0, LW, 1, E_DEC,   "lw_decode");
        step(0, R,  0, E_MADDR, "lw_addr");
        step(0, R,  0, E_MRD,   "lw_wait1");
        step(0, R,  0, E_MRD,   "lw_wait2");
        step(0, R,  0, E_MRD,   "lw_wait3");
        step(0, R,  1, E_MRD,   "lw_ready");
        step(0, R,  1, E_MWB,   "lw_wb");
        // sw; opcode input changed after DECODE must not matter
        step(0, SW, 1, E_FRDY,  "sw_fetch");
        step(0, SW, 1, E_DEC,   "sw_decode");
        step(0, R,  0, E_MADDR, "sw_addr");
        step(0, R,  0, E_MWR,   "sw_wait");
        step(0, R,  1, E_MWR,   "sw_ready");
        step(0, BEQ, 1, E_FRDY, "beq_fetch");
        step(0, BEQ, 1, E_DEC,  "beq_decode");
        step(0, R,   1, E_BEQ,  "beq_branch");
        step(0, BNE, 1, E_FRDY, "bne_fetch");
        step(0, BNE, 1, E_DEC,  "bne_decode");
        step(0, R,   1, E_BNE,  "bne_branch");
        step(0, J,   1, E_FRDY, "j_fetch");
        step(0, J,   1, E_DEC,  "j_decode");
        step(0, R,   1, E_JMP,  "j_jump");
        step(0, ORI, 1, E_FRDY, "ori_fetch");
        step(0, ORI, 1, E_DEC,  "ori_decode");
        step(0, R,   1, E_IEX0, "ori_exec");
        step(0, R,   1, E_IWB,  "ori_wb");
        step(0, ADDI, 1, E_FRDY, "addi_fetch");
        step(0, ADDI, 1, E_DEC,  "addi_decode");
        step(0, R,    1, E_IEX1, "addi_exec");
        step(0, R,    1, E_IWB,  "addi_wb");
        step(0, BAD, 1, E_FRDY, "bad_fetch");
        step(0, BAD, 1, E_DEC,  "bad_decode");
`ifdef ILLEGAL_TRAP_EN
        step(0, R, 1, E_TRAP, "trap1");
        step(0, R, 1, E_TRAP, "trap_hold");
        step(1, R, 1, E_ZERO, "trap_rst");
`endif
        // FETCH: 3 wait cycles, then ready on the would-be timeout cycle
        step(0, J, 0, E_FWAIT, "fwait1");
        step(0, J, 0, E_FWAIT, "fwait2");
        step(0, J, 0, E_FWAIT, "fwait3");
        step(0, J, 1, E_FRDY,  "fready_wins");
        step(0, J, 1, E_DEC,   "fw_decode");
        step(0, R, 1, E_JMP,   "fw_jump");
        // reset during MEM_WB suppresses reg_write
        step(0, LW, 1, E_FRDY,  "lw2_fetch");
        step(0, LW, 1, E_DEC,   "lw2_decode");
        step(0, R,  1, E_MADDR, "lw2_addr");
        step(0, R,  1, E_MRD,   "lw2_read");
        step(1, R,  1, E_ZERO,  "rst_in_memwb");
        // timeout from FETCH after 4 wait cycles
        step(0, R, 0, E_FWAIT, "to_wait1");
        step(0, R, 0, E_FWAIT, "to_wait2");
        step(0, R, 0, E_FWAIT, "to_wait3");
        step(0, R, 0, E_FWAIT, "to_wait4");
        step(0, R, 1, E_ERR,   "err_entered");
        step(0, R, 1, E_ERR,   "err_hold");
        step(1, R, 1, E_ZERO,  "err_rst");
        step(0, R, 1, E_FRDY,  "after_err_fetch");

        for (int i = 0; i < 10 && sbq.size() > 0; i++)
            @(posedge clk);
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
